// File: rtl/fe_pkg.sv
// Shared definitions for the front-end request arbiter: register map and FSM encoding.
package fe_pkg;

    // FE register window addresses
    localparam logic [1:0] FE_REG_GRANT = 2'd0;
    localparam logic [1:0] FE_REG_RQ    = 2'd1;
    localparam logic [1:0] FE_REG_DROP  = 2'd2;
    localparam logic [1:0] FE_REG_INFO  = 2'd3;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } fe_state_e;

    // Increment an index modulo n
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set bit at or after a pointer, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [N-1:0]   i_vec,
    input  logic [IDW-1:0] i_ptr,
    output logic [IDW-1:0] o_idx,
    output logic           o_valid
);

    // Scan positions ptr, ptr+1, ... (mod N) and take the first requester found
    always_comb begin
        int unsigned w_pos;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            w_pos = (32'(i_ptr) + k) % N;
            for (int unsigned b = 0; b < N; b++) begin
                if (!o_valid && (b == w_pos) && i_vec[b]) begin
                    o_idx   = IDW'(b);
                    o_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fe_req_arb.sv
// Round-robin arbiter sharing the FE Avalon data channel between N requesting devices.
module fe_req_arb
    import fe_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDW   = 2,
    parameter int unsigned DROPW = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] dev_rq,
    output logic [N-1:0] dev_write,
    output logic [31:0]  dev_writedata,
    input  logic [1:0]   s_address,
    input  logic         s_read,
    output logic [31:0]  s_readdata,
    input  logic         s_write,
    input  logic [31:0]  s_writedata
);

    fe_state_e        r_state;
    fe_state_e        w_state_nxt;
    logic [N-1:0]     r_rq_q;
    logic [IDW-1:0]   r_grant;
    logic [IDW-1:0]   w_grant_nxt;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   w_ptr_nxt;
    logic [IDW-1:0]   w_grant_inc;
    logic [IDW-1:0]   w_pick_idx;
    logic             w_pick_valid;
    logic             r_post_hold;
    logic             w_strobe;
    logic             w_fe_data_wr;
    logic             w_drop_wr;
    logic             w_drop_clr;
    logic             w_grant_rq;
    logic [N-1:0]     w_grant_oh;
    logic [N-1:0]     w_arb_vec;
    logic [DROPW-1:0] r_drop_cnt;
    logic             w_unused_read;

    // Reads carry no side effects; the strobe is not needed to form read data
    assign w_unused_read = s_read;

    assign w_fe_data_wr = s_write && (s_address == FE_REG_GRANT);
    assign w_drop_clr   = s_write && (s_address == FE_REG_RQ);
    assign w_drop_wr    = w_fe_data_wr && (r_state != ST_GRANT);
    assign w_grant_inc  = IDW'(wrap_inc(32'(r_grant), N));
    assign w_grant_rq   = |(r_rq_q & w_grant_oh);

    // One-hot decode of the current grant index
    always_comb begin
        w_grant_oh = '0;
        for (int unsigned b = 0; b < N; b++) begin
            if (32'(r_grant) == b) begin
                w_grant_oh[b] = 1'b1;
            end
        end
    end

    // The just-serviced device is hidden for the IDLE cycle after HOLD to absorb its request-clear latency
    assign w_arb_vec = r_post_hold ? (r_rq_q & ~w_grant_oh) : r_rq_q;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_pick (
        .i_vec   (w_arb_vec),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // Next-state logic: arbitrate in IDLE, service or abandon in GRANT, single-cycle HOLD
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_rr_ptr;
        w_strobe    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_grant_nxt = w_pick_idx;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_fe_data_wr) begin
                    w_strobe    = 1'b1;
                    w_ptr_nxt   = w_grant_inc;
                    w_state_nxt = ST_HOLD;
                end else if (!w_grant_rq) begin
                    w_ptr_nxt   = w_grant_inc;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state, grant, pointer and request sampling registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_post_hold <= 1'b0;
            r_rq_q      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_rr_ptr    <= w_ptr_nxt;
            r_post_hold <= (r_state == ST_HOLD);
            r_rq_q      <= dev_rq;
        end
    end

    // One-cycle write strobe to the granted device, with data captured from the FE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dev_write     <= '0;
            dev_writedata <= '0;
        end else begin
            dev_write <= w_strobe ? w_grant_oh : '0;
            if (w_strobe) begin
                dev_writedata <= s_writedata;
            end
        end
    end

    // Saturating count of FE data writes arriving with no grant; clear has priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop_clr) begin
            r_drop_cnt <= '0;
        end else if (w_drop_wr && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + DROPW'(1);
        end
    end

    // FE register read mux
    always_comb begin
        s_readdata = '0;
        case (s_address)
            FE_REG_GRANT: begin
                s_readdata[31]      = (r_state == ST_GRANT);
                s_readdata[IDW-1:0] = r_grant;
            end
            FE_REG_RQ: begin
                s_readdata[N-1:0] = r_rq_q;
            end
            FE_REG_DROP: begin
                s_readdata[DROPW-1:0] = r_drop_cnt;
            end
            default: begin
                s_readdata[7:0] = 8'(N);
            end
        endcase
    end

endmodule

// File: tb/tb_fe_req_arb.sv
// Randomized and directed bench for fe_req_arb against a transaction-level reference model.
`timescale 1ns/1ps
module tb_fe_req_arb;

    localparam int unsigned N     = 4;
    localparam int unsigned IDW   = 2;
    localparam int unsigned DROPW = 16;
    localparam int unsigned DROP_MAX = (1 << DROPW) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] dev_rq;
    logic [N-1:0] dev_write;
    logic [31:0]  dev_writedata;
    logic [1:0]   s_address;
    logic         s_read;
    logic [31:0]  s_readdata;
    logic         s_write;
    logic [31:0]  s_writedata;

    always #5 clk = ~clk;

    fe_req_arb #(
        .N     (N),
        .IDW   (IDW),
        .DROPW (DROPW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .dev_rq        (dev_rq),
        .dev_write     (dev_write),
        .dev_writedata (dev_writedata),
        .s_address     (s_address),
        .s_read        (s_read),
        .s_readdata    (s_readdata),
        .s_write       (s_write),
        .s_writedata   (s_writedata)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp_v);
        end
    endtask

    // Reference model: who holds the channel, whether the post-service window is open
    bit           m_busy;
    bit           m_hold;
    bit           m_after;
    int unsigned  m_grant;
    int unsigned  m_ptr;
    int unsigned  m_drop;
    bit [N-1:0]   m_rq_q;
    bit [N-1:0]   m_strobe;
    bit [31:0]    m_wdata;

    task automatic model_reset();
        m_busy = 0; m_hold = 0; m_after = 0;
        m_grant = 0; m_ptr = 0; m_drop = 0;
        m_rq_q = '0; m_strobe = '0; m_wdata = '0;
    endtask

    task automatic model_step(input logic [N-1:0] rq, input logic wr, input logic [1:0] addr,
                              input logic [31:0] wd);
        bit fe_wr;
        int unsigned nd;
        int unsigned g;
        fe_wr = wr && (addr == 2'd0);
        if (wr && addr == 2'd1) nd = 0;
        else if (fe_wr && !m_busy && m_drop < DROP_MAX) nd = m_drop + 1;
        else nd = m_drop;
        m_strobe = '0;
        if (m_busy) begin
            if (fe_wr) begin
                m_strobe[m_grant] = 1'b1;
                m_wdata = wd;
                m_ptr = (m_grant + 1) % N;
                m_busy = 0;
                m_hold = 1;
            end else if (!m_rq_q[m_grant]) begin
                m_ptr = (m_grant + 1) % N;
                m_busy = 0;
            end
            m_after = 0;
        end else if (m_hold) begin
            m_hold = 0;
            m_after = 1;
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                g = (m_ptr + k) % N;
                if (m_rq_q[g] && !(m_after && g == m_grant)) begin
                    m_grant = g;
                    m_busy = 1;
                    break;
                end
            end
            m_after = 0;
        end
        m_drop = nd;
        m_rq_q = rq;
    endtask

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {m_busy, 31'(m_grant)};
            2'd1:    return 32'(m_rq_q);
            2'd2:    return 32'(m_drop);
            default: return 32'(N);
        endcase
    endfunction

    // One clock: drive at negedge, advance model, compare at next negedge
    task automatic cyc(input logic [N-1:0] rq, input logic wr, input logic [1:0] addr,
                       input logic [31:0] wd);
        dev_rq = rq; s_write = wr; s_address = addr; s_writedata = wd; s_read = ~wr;
        model_step(rq, wr, addr, wd);
        @(negedge clk);
        check("dev_write", 32'(dev_write), 32'(m_strobe));
        check("dev_writedata", dev_writedata, m_wdata);
        check("readdata", s_readdata, model_rd(addr));
    endtask

    task automatic wait_grant(input logic [N-1:0] rq, output int unsigned idx);
        int unsigned t;
        t = 0;
        cyc(rq, 1'b0, 2'd0, 32'd0);
        while (!s_readdata[31] && t < 20) begin
            cyc(rq, 1'b0, 2'd0, 32'd0);
            t++;
        end
        check("wait_grant", 32'(s_readdata[31]), 32'd1);
        idx = 32'(s_readdata[IDW-1:0]);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned g;
        int unsigned rr_exp[5];
        logic [N-1:0] rq;
        logic         wr;
        logic [1:0]   addr;
        rr_exp = '{0, 1, 2, 3, 0};

        reset = 1'b0; dev_rq = '0; s_write = 1'b0; s_read = 1'b0;
        s_address = 2'd0; s_writedata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_dev_write", 32'(dev_write), 32'd0);
        check("rst_dev_writedata", dev_writedata, 32'd0);
        for (int a = 0; a < 4; a++) begin
            s_address = 2'(a);
            #1;
            check("rst_regs", s_readdata, model_rd(2'(a)));
        end
        @(negedge clk);
        reset = 1'b1;

        // Round-robin fairness with all devices requesting
        for (int i = 0; i < 5; i++) begin
            wait_grant(4'hF, g);
            check("rr_seq", g, rr_exp[i]);
            cyc(4'hF, 1'b1, 2'd0, 32'h100 + 32'(i));
            check("rr_strobe", 32'(dev_write), 32'(1) << rr_exp[i]);
        end
        repeat (4) cyc('0, 1'b0, 2'd0, 32'd0);

        // Single requester: grant in two cycles, strobe, HOLD, IDLE
        cyc(4'b0010, 1'b0, 2'd0, 32'd0);
        cyc(4'b0010, 1'b0, 2'd0, 32'd0);
        check("single_grant", s_readdata, 32'h8000_0001);
        cyc(4'b0010, 1'b1, 2'd0, 32'h1A5);
        check("single_strobe", 32'(dev_write), 32'h2);
        check("single_data", dev_writedata, 32'h1A5);
        cyc('0, 1'b0, 2'd0, 32'd0);
        check("single_hold", s_readdata, 32'h1);
        check("single_one_cycle", 32'(dev_write), 32'd0);
        repeat (2) cyc('0, 1'b0, 2'd0, 32'd0);

        // Device drops request while granted, then a write is dropped
        cyc('0, 1'b1, 2'd1, 32'd0);
        wait_grant(4'b0100, g);
        check("drop_grant", g, 32'd2);
        cyc('0, 1'b0, 2'd0, 32'd0);
        cyc('0, 1'b0, 2'd0, 32'd0);
        check("drop_idle", 32'(s_readdata[31]), 32'd0);
        cyc('0, 1'b1, 2'd0, 32'hDEAD);
        check("drop_nostrobe", 32'(dev_write), 32'd0);
        cyc('0, 1'b0, 2'd2, 32'd0);
        check("drop_cnt", s_readdata, 32'd1);

        // Stale request for one cycle after the strobe must not be re-granted
        wait_grant(4'b0010, g);
        check("stale_grant", g, 32'd1);
        cyc(4'b0010, 1'b1, 2'd0, 32'h55);
        cyc(4'b0010, 1'b0, 2'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc('0, 1'b0, 2'd0, 32'd0);
            check("stale_masked", 32'(s_readdata[31]), 32'd0);
        end
        // Request still high after the masking window is granted again
        wait_grant(4'b0010, g);
        cyc(4'b0010, 1'b1, 2'd0, 32'h66);
        cyc(4'b0010, 1'b0, 2'd0, 32'd0);
        check("regrant_hold", 32'(s_readdata[31]), 32'd0);
        cyc(4'b0010, 1'b0, 2'd0, 32'd0);
        check("regrant_masked", 32'(s_readdata[31]), 32'd0);
        cyc(4'b0010, 1'b0, 2'd0, 32'd0);
        check("regrant", s_readdata, 32'h8000_0001);
        repeat (3) cyc('0, 1'b0, 2'd0, 32'd0);

        // Drop counter saturation and clear
        cyc('0, 1'b1, 2'd1, 32'd0);
        for (int i = 0; i < 65540; i++) cyc('0, 1'b1, 2'd0, 32'(i));
        cyc('0, 1'b0, 2'd2, 32'd0);
        check("drop_sat", s_readdata, 32'h0000_FFFF);
        cyc('0, 1'b1, 2'd1, 32'd0);
        cyc('0, 1'b0, 2'd2, 32'd0);
        check("drop_clear", s_readdata, 32'd0);

        // Asynchronous reset in GRANT with a write pending
        wait_grant(4'hF, g);
        dev_rq = 4'hF; s_write = 1'b1; s_address = 2'd0; s_writedata = 32'hBAD;
        #2 reset = 1'b0;
        #1 check("rst_async_rd", s_readdata, 32'd0);
        @(posedge clk);
        #1;
        check("rst_mid_write", 32'(dev_write), 32'd0);
        check("rst_mid_rd", s_readdata, 32'd0);
        @(negedge clk);
        s_write = 1'b0;
        reset = 1'b1;
        model_reset();
        wait_grant(4'hF, g);
        check("rst_ptr", g, 32'd0);

        // Randomized traffic against the model
        rq = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rq = N'($urandom);
            wr = ($urandom_range(0, 9) < 4);
            addr = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'd0;
            cyc(rq, wr, addr, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
